// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_unit
// Description : Multi-cycle MIPS MULT/MULTU/DIV/DIVU sequencer that owns the
//               architectural HI/LO registers. Sits beside the EX-stage ALU,
//               runs a shift-add multiply or a restoring divide over WIDTH
//               iterations and raises busy so the pipeline stalls MFHI/MFLO
//               and further mul/div issue.
// Ports       : CLK     in   clock, all state updates on posedge
//               RST     in   synchronous reset, active-low
//               start   in   operation request, sampled only while idle
//               op      in   00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//               Rdata1  in   rs: multiplicand / dividend, MTHI/MTLO data
//               Rdata2  in   rt: multiplier / divisor
//               mthi    in   write Rdata1 into HI (idle only)
//               mtlo    in   write Rdata1 into LO (idle only)
//               busy    out  sequencer not idle
//               done    out  one-cycle pulse, new HI/LO valid in that cycle
//               HI      out  product high half / remainder
//               LO      out  product low half / quotient
// Config      : FAST_MUL_EN - when defined, MULT/MULTU use a single-cycle
//               multiplier and skip the iterative phase (2-cycle latency).
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Rdata1,
    input  logic [WIDTH-1:0] Rdata2,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    localparam int                 c_CNT_W = $clog2(WIDTH) + 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_next;

    logic [c_CNT_W-1:0]   r_cnt;
    // Shared accumulator: multiply {partial product, multiplier},
    // divide {partial remainder, dividend/quotient}.
    logic [2*WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]     r_opb;     // multiplicand or divisor magnitude
    logic [WIDTH-1:0]     r_raw1;    // original rs, returned in HI on divide by zero
    logic                 r_is_div;
    logic                 r_neg_q;   // product / quotient sign
    logic                 r_neg_r;   // remainder sign
    logic                 r_done;
    logic [WIDTH-1:0]     r_hi;
    logic [WIDTH-1:0]     r_lo;

    // ------------------------------------------------------------------
    // Operand conditioning: signed ops work on magnitudes plus sign flags
    // ------------------------------------------------------------------
    logic                 w_signed;
    logic                 w_s1;
    logic                 w_s2;
    logic [WIDTH-1:0]     w_abs1;
    logic [WIDTH-1:0]     w_abs2;
    logic                 w_fast;

    assign w_signed = ~op[0];
    assign w_s1     = w_signed & Rdata1[WIDTH-1];
    assign w_s2     = w_signed & Rdata2[WIDTH-1];
    assign w_abs1   = w_s1 ? -Rdata1 : Rdata1;
    assign w_abs2   = w_s2 ? -Rdata2 : Rdata2;

`ifdef FAST_MUL_EN
    logic [2*WIDTH-1:0]   w_fast_prod;
    assign w_fast_prod = {{WIDTH{1'b0}}, w_abs1} * {{WIDTH{1'b0}}, w_abs2};
    assign w_fast      = ~op[1];
`else
    assign w_fast      = 1'b0;
`endif

    // ------------------------------------------------------------------
    // One iteration of each algorithm
    // ------------------------------------------------------------------
    logic [WIDTH:0]       w_mul_sum;
    logic [2*WIDTH-1:0]   w_mul_next;
    logic [WIDTH:0]       w_rem_sh;
    logic [WIDTH+1:0]     w_diff;
    logic [2*WIDTH-1:0]   w_div_next;

    // Add multiplicand into the upper half when the multiplier LSB is set,
    // then shift the whole accumulator right keeping the add carry.
    assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, r_opb};
    assign w_mul_next = r_acc[0] ? {w_mul_sum, r_acc[WIDTH-1:1]}
                                 : {1'b0, r_acc[2*WIDTH-1:1]};

    // Shift remainder left pulling in the next dividend bit; the MSB of
    // the difference is the borrow, so a clear MSB means quotient bit 1.
    assign w_rem_sh   = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff     = {1'b0, w_rem_sh} - {2'b00, r_opb};
    assign w_div_next = w_diff[WIDTH+1]
                      ? {w_rem_sh[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0}
                      : {w_diff[WIDTH-1:0],   r_acc[WIDTH-2:0], 1'b1};

    // ------------------------------------------------------------------
    // Sign fix-up applied in the final state
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     w_q_mag;
    logic [WIDTH-1:0]     w_r_mag;
    logic [2*WIDTH-1:0]   w_prod;
    logic [WIDTH-1:0]     w_quo;
    logic [WIDTH-1:0]     w_rem;
    logic                 w_div0;

    assign w_q_mag = r_acc[WIDTH-1:0];
    assign w_r_mag = r_acc[2*WIDTH-1:WIDTH];
    assign w_prod  = r_neg_q ? -r_acc : r_acc;
    assign w_quo   = r_neg_q ? -w_q_mag : w_q_mag;
    assign w_rem   = r_neg_r ? -w_r_mag : w_r_mag;
    assign w_div0  = (r_opb == '0);

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (start) w_next = w_fast ? S_FIX : S_CALC;
            S_CALC: if (r_cnt == c_LAST) w_next = S_FIX;
            S_FIX:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and architectural registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (!RST) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_opb    <= '0;
            r_raw1   <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_done   <= 1'b0;
            r_hi     <= '0;
            r_lo     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        // start wins over a simultaneous MTHI/MTLO
                        r_cnt    <= '0;
                        r_is_div <= op[1];
                        r_neg_q  <= w_s1 ^ w_s2;
                        r_neg_r  <= w_s1;
                        r_raw1   <= Rdata1;
                        if (op[1]) begin
                            r_opb <= w_abs2;
                            r_acc <= {{WIDTH{1'b0}}, w_abs1};
                        end else begin
                            r_opb <= w_abs1;
`ifdef FAST_MUL_EN
                            r_acc <= w_fast_prod;
`else
                            r_acc <= {{WIDTH{1'b0}}, w_abs2};
`endif
                        end
                    end else begin
                        if (mthi) r_hi <= Rdata1;
                        if (mtlo) r_lo <= Rdata1;
                    end
                end
                S_CALC: begin
                    r_cnt <= r_cnt + c_CNT_W'(1);
                    r_acc <= r_is_div ? w_div_next : w_mul_next;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (!r_is_div) begin
                        r_hi <= w_prod[2*WIDTH-1:WIDTH];
                        r_lo <= w_prod[WIDTH-1:0];
                    end else if (w_div0) begin
                        r_hi <= r_raw1;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != S_IDLE);
    assign done = r_done;
    assign HI   = r_hi;
    assign LO   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_unit
// Description : Self-checking bench for muldiv_unit. Directed vectors plus
//               randomized operations compared against an arithmetic model
//               of HI/LO; also checks latency, busy length, MTHI/MTLO,
//               ignored restarts and mid-operation reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        RST;
    logic        start;
    logic [1:0]  op;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic        mthi;
    logic        mtlo;
    logic        busy;
    logic        done;
    logic [31:0] HI;
    logic [31:0] LO;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    always #5 clk = ~clk;

    muldiv_unit #(.WIDTH(32)) dut (
        .CLK    (clk),
        .RST    (RST),
        .start  (start),
        .op     (op),
        .Rdata1 (Rdata1),
        .Rdata2 (Rdata2),
        .mthi   (mthi),
        .mtlo   (mtlo),
        .busy   (busy),
        .done   (done),
        .HI     (HI),
        .LO     (LO)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Reference: MIPS semantics via plain 64-bit arithmetic, returns {HI,LO}
    function automatic logic [63:0] ref_op(input logic [1:0] o, input logic [31:0] a,
                                           input logic [31:0] b);
        longint      sa;
        longint      sb;
        longint      q;
        longint      r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p  = '0;
        case (o)
            2'd0: p = 64'(sa * sb);
            2'd1: p = {32'b0, a} * {32'b0, b};
            2'd2: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else begin
                    q = sa / sb;
                    r = sa % sb;
                    p = {r[31:0], q[31:0]};
                end
            end
            default: begin
                if (b == 0) p = {a, 32'hFFFF_FFFF};
                else p = {a % b, a / b};
            end
        endcase
        return p;
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            4: return -32'($urandom_range(1, 20));
            default: return 32'($urandom);
        endcase
    endfunction

    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit poke, input bit with_mt);
        logic [63:0] exp;
        int          lat;
        int          busy_cnt;
        int          exp_lat;
        exp     = ref_op(o, a, b);
        exp_lat = 34;
`ifdef FAST_MUL_EN
        if (!o[1]) exp_lat = 2;
`endif
        @(negedge clk);
        start  = 1'b1;
        op     = o;
        Rdata1 = a;
        Rdata2 = b;
        mthi   = with_mt;
        mtlo   = with_mt;
        @(posedge clk);
        #1;
        start    = 1'b0;
        mthi     = 1'b0;
        mtlo     = 1'b0;
        Rdata1   = $urandom;
        Rdata2   = $urandom;
        lat      = 1;
        busy_cnt = 0;
        // HI/LO keep the old value while the operation runs
        check("hold", {HI, LO}, {m_hi, m_lo});
        while (!done && lat < 100) begin
            if (busy) busy_cnt++;
            if (poke && lat == 5) begin
                start  = 1'b1;
                op     = ~o;
                Rdata1 = $urandom;
                Rdata2 = $urandom;
            end
            if (poke && lat == 6) start = 1'b0;
            @(posedge clk);
            #1;
            lat++;
        end
        start = 1'b0;
        if (!done) begin
            check("done_timeout", 64'(done), 64'd1);
            return;
        end
        check("latency", 64'(lat), 64'(exp_lat));
        check("busy_cycles", 64'(busy_cnt), 64'(exp_lat - 1));
        check($sformatf("HI op%0d %h,%h", o, a, b), 64'(HI), 64'(exp[63:32]));
        check($sformatf("LO op%0d %h,%h", o, a, b), 64'(LO), 64'(exp[31:0]));
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        if (poke) begin
            repeat (3) begin
                @(posedge clk);
                #1;
                check("no_requeue", {62'b0, busy, done}, 64'd0);
            end
        end
    endtask

    task automatic mt_write(input bit h, input bit l, input logic [31:0] v);
        @(negedge clk);
        mthi   = h;
        mtlo   = l;
        Rdata1 = v;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        if (h) m_hi = v;
        if (l) m_lo = v;
        check("mt_hi", 64'(HI), 64'(m_hi));
        check("mt_lo", 64'(LO), 64'(m_lo));
        check("mt_done", 64'(done), 64'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit saw_done;
        RST    = 1'b0;
        start  = 1'b0;
        op     = 2'b00;
        Rdata1 = '0;
        Rdata2 = '0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        m_hi   = '0;
        m_lo   = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_state", {28'b0, busy, done, 34'b0}, 64'd0);
        check("rst_hilo", {HI, LO}, 64'd0);
        @(negedge clk);
        RST = 1'b1;

        // Directed vectors
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd0, 32'hFFFF_FFFD, 32'h0000_0005, 0, 0);
        run_op(2'd0, 32'h8000_0000, 32'h8000_0000, 0, 0);
        run_op(2'd2, 32'hFFFF_FFF9, 32'h0000_0002, 0, 0);
        run_op(2'd3, 32'h0000_0007, 32'h0000_0002, 0, 0);
        run_op(2'd2, 32'h0000_0007, 32'hFFFF_FFFE, 0, 0);
        run_op(2'd2, 32'h0000_1234, 32'h0000_0000, 0, 0);
        run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        run_op(2'd1, 32'd6, 32'd7, 0, 0);
        run_op(2'd3, 32'd42, 32'd6, 0, 0);

        // MTHI / MTLO
        mt_write(1, 0, 32'hA5A5_A5A5);
        mt_write(0, 1, 32'h5A5A_0F0F);
        mt_write(1, 1, 32'h1357_9BDF);

        // Restart while busy is ignored; start beats a simultaneous MT write
        run_op(2'd3, 32'($urandom), 32'($urandom_range(1, 1000)), 1, 0);
        run_op(2'd2, 32'($urandom), 32'($urandom), 0, 1);

        // Reset in the middle of a divide
        @(negedge clk);
        start  = 1'b1;
        op     = 2'd3;
        Rdata1 = 32'd100;
        Rdata2 = 32'd7;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        @(negedge clk);
        RST = 1'b0;
        @(posedge clk);
        #1;
        check("rst_mid_busy", {62'b0, busy, done}, 64'd0);
        check("rst_mid_hilo", {HI, LO}, 64'd0);
        m_hi = '0;
        m_lo = '0;
        @(negedge clk);
        RST      = 1'b1;
        saw_done = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done || busy) saw_done = 1'b1;
        end
        check("rst_mid_quiet", 64'(saw_done), 64'd0);

        // Randomized operations with occasional MT writes
        for (int i = 0; i < 40; i++) begin
            run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 0);
            if ($urandom_range(0, 4) == 0)
                mt_write(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
